// File: rtl/fsb_block_responder.sv
// Responder for the core's dcache/icache front-side buses: round-robin
// arbitration, then each cache block is moved as single-word memory beats.
module fsb_block_responder #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      abort_bus,
    input  logic                      d_req,
    input  logic                      d_wen,
    input  logic [ADDR_W-1:0]         d_addr,
    input  logic [32*BLOCK_WORDS-1:0] d_wdata,
    output logic                      d_done,
    output logic [32*BLOCK_WORDS-1:0] d_rdata,
    input  logic                      i_req,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic                      i_done,
    output logic [32*BLOCK_WORDS-1:0] i_rdata,
    output logic                      mem_req,
    output logic                      mem_wen,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_ready,
    input  logic [31:0]               mem_rdata,
    output logic                      busy,
    output logic                      owner
);

    localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(BLOCK_WORDS * 4 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                state;
    logic [BEAT_W-1:0]         beat;
    logic [ADDR_W-1:0]         base;
    logic                      wen;
    logic [32*BLOCK_WORDS-1:0] wdata;

    logic grant_any;
    logic grant_d;
    logic in_beat;

    // owner doubles as last_owner: on a tie the port that did not go last wins.
    assign grant_any = !abort_bus && (d_req || i_req);
    assign grant_d   = d_req && (!i_req || !owner);
    assign in_beat   = (state == S_BEAT);

    always_comb begin
        mem_req   = in_beat;
        mem_wen   = in_beat && wen;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_beat) begin
            mem_addr  = base | (ADDR_W'(beat) << 2);
            mem_wdata = wdata[32*beat +: 32];
        end
    end

    assign busy   = (state != S_IDLE);
    assign d_done = (state == S_DONE) && owner && !abort_bus;
    assign i_done = (state == S_DONE) && !owner && !abort_bus;

    // NOTE: the rdata buffers are visible outputs that must read 0 after
    // reset, so they sit in the reset branch like any other register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            beat    <= '0;
            base    <= '0;
            wen     <= 1'b0;
            wdata   <= '0;
            owner   <= 1'b0;
            d_rdata <= '0;
            i_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge value of state, beat and owner.
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner <= grant_d;
                        base  <= (grant_d ? d_addr : i_addr) & ~BLOCK_MASK;
                        wen   <= grant_d && d_wen;
                        if (grant_d) begin
                            wdata <= d_wdata;
                        end
                        beat  <= '0;
                        state <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (mem_ready) begin
                        if (!wen) begin
                            if (owner) begin
                                d_rdata[32*beat +: 32] <= mem_rdata;
                            end else begin
                                i_rdata[32*beat +: 32] <= mem_rdata;
                            end
                        end
                        if (beat == LAST_BEAT) begin
                            state <= S_DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                    // A beat accepted this cycle still lands; the block is then dropped.
                    if (abort_bus) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsb_block_responder.sv
// Directed bench for fsb_block_responder: a per-cycle vector table plus
// hand-written sequences for async reset and completion latency.
module tb_fsb_block_responder;

    localparam int BW = 4;
    localparam int AW = 32;

    logic              CLK;
    logic              RST;
    logic              abort_bus;
    logic              d_req;
    logic              d_wen;
    logic [AW-1:0]     d_addr;
    logic [32*BW-1:0]  d_wdata;
    logic              d_done;
    logic [32*BW-1:0]  d_rdata;
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_done;
    logic [32*BW-1:0]  i_rdata;
    logic              mem_req;
    logic              mem_wen;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              owner;

    fsb_block_responder #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .abort_bus(abort_bus),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, abort, dreq, dwen;
        logic [31:0] daddr;
        logic        ireq;
        logic [31:0] iaddr;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req, e_wen;
        logic [31:0] e_addr, e_wdata;
        logic        e_dd, e_id, e_busy, e_own;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mark_a, mark_b, mark_c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [69:0] pack_outputs();
        return {mem_req, mem_wen, mem_addr, mem_wdata, d_done, i_done, busy, owner};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
    task automatic apply(input vec_t v, input int idx);
        @(posedge CLK);
        #1;
        RST       = v.rst;
        abort_bus = v.abort;
        d_req     = v.dreq;
        d_wen     = v.dwen;
        d_addr    = v.daddr;
        i_req     = v.ireq;
        i_addr    = v.iaddr;
        mem_ready = v.rdy;
        mem_rdata = v.rdata;
        @(negedge CLK);
        check($sformatf("vec%0d", idx), 128'(pack_outputs()),
              128'({v.e_req, v.e_wen, v.e_addr, v.e_wdata, v.e_dd, v.e_id, v.e_busy, v.e_own}));
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(vecs[i], i);
    endtask

    task automatic build();
        // rst,abort,dreq,dwen,daddr,ireq,iaddr,rdy,rdata | req,wen,addr,wdata,dd,id,busy,own
        // dcache read at 0x8000_0014: beats 0x10..0x1C, done in cycle 5
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'hA0, 0,0,32'h0,32'h0,0,0,0,0});
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'hA0, 1,0,32'h80000010,32'h11,0,0,1,1});
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'hA1, 1,0,32'h80000014,32'h22,0,0,1,1});
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'hA2, 1,0,32'h80000018,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'hA3, 1,0,32'h8000001C,32'h44,0,0,1,1});
        vecs.push_back('{0,0,1,0,32'h80000014,0,32'h0,1,32'h00, 0,0,32'h0,32'h0,1,0,1,1});
        vecs.push_back('{0,0,0,0,32'h0,0,32'h0,0,32'h00, 0,0,32'h0,32'h0,0,0,0,1});
        mark_a = vecs.size();
        // dcache write at 0x100
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 0,0,32'h0,32'h0,0,0,0,1});
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 1,1,32'h100,32'h11,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 1,1,32'h104,32'h22,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 1,1,32'h108,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 1,1,32'h10C,32'h44,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h100,0,32'h0,1,32'hDEAD, 0,0,32'h0,32'h0,1,0,1,1});
        vecs.push_back('{0,0,0,0,32'h0,0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0,0,0,1});
        // dcache write at 0x40, beat 2 stalled three cycles: done moves from cycle 5 to 8
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,1,32'h0, 0,0,32'h0,32'h0,0,0,0,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,1,32'h0, 1,1,32'h40,32'h11,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,0,32'h0, 1,1,32'h44,32'h22,0,0,1,1});
        vecs[vecs.size()-1].rdy = 1'b1;
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,0,32'h0, 1,1,32'h48,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,0,32'h0, 1,1,32'h48,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,0,32'h0, 1,1,32'h48,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,1,32'h0, 1,1,32'h48,32'h33,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,1,32'h0, 1,1,32'h4C,32'h44,0,0,1,1});
        vecs.push_back('{0,0,1,1,32'h40,0,32'h0,1,32'h0, 0,0,32'h0,32'h0,1,0,1,1});
        vecs.push_back('{0,0,0,0,32'h0,0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0,0,0,1});
        mark_b = vecs.size();
        // both ports requesting from reset: grants go dcache, icache, dcache
        vecs.push_back('{1,0,1,0,32'h300,1,32'h200,1,32'h50, 0,0,32'h0,32'h0,0,0,0,0});
        vecs.push_back('{0,0,1,0,32'h300,1,32'h200,1,32'h50, 0,0,32'h0,32'h0,0,0,0,0});
        for (int t = 0; t < 3; t++) begin
            logic        own;
            logic [31:0] base;
            own  = (t != 1);
            base = own ? 32'h300 : 32'h200;
            for (int b = 0; b < 4; b++)
                vecs.push_back('{0,0,1,0,32'h300,1,32'h200,1,32'h50,
                                 1,0,base + 32'(4*b),32'h11 * 32'(b+1),0,0,1,own});
            vecs.push_back('{0,0,(t != 2),0,32'h300,(t != 2),32'h200,1,32'h50,
                             0,0,32'h0,32'h0,own,!own,1,own});
            vecs.push_back('{0,0,(t != 2),0,32'h300,(t != 2),32'h200,1,32'h50,
                             0,0,32'h0,32'h0,0,0,0,own});
        end
        // icache fill at 0x1000: abort_bus in IDLE blocks the grant; abort in beat 1 cancels
        vecs[vecs.size()-1].abort = 1'b1;
        vecs[vecs.size()-1].ireq  = 1'b1;
        vecs[vecs.size()-1].iaddr = 32'h1000;
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h70, 0,0,32'h0,32'h0,0,0,0,1});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h70, 1,0,32'h1000,32'h11,0,0,1,0});
        vecs.push_back('{0,1,0,0,32'h0,1,32'h1000,1,32'h71, 1,0,32'h1004,32'h22,0,0,1,0});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h80, 0,0,32'h0,32'h0,0,0,0,0});
        mark_c = vecs.size();
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h80, 1,0,32'h1000,32'h11,0,0,1,0});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h81, 1,0,32'h1004,32'h22,0,0,1,0});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h82, 1,0,32'h1008,32'h33,0,0,1,0});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h83, 1,0,32'h100C,32'h44,0,0,1,0});
        vecs.push_back('{0,0,0,0,32'h0,1,32'h1000,1,32'h0, 0,0,32'h0,32'h0,0,1,1,0});
        vecs.push_back('{0,0,0,0,32'h0,0,32'h0,0,32'h0, 0,0,32'h0,32'h0,0,0,0,0});
    endtask

    initial begin
        int done_cyc;
        int n_done;
        RST = 1'b1; abort_bus = 1'b0; d_req = 1'b0; d_wen = 1'b0; d_addr = '0;
        i_req = 1'b0; i_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
        d_wdata = 128'h00000044_00000033_00000022_00000011;
        build();

        @(posedge CLK);
        #1;
        check("reset_outputs", 128'(pack_outputs()), 128'h0);
        check("reset_d_rdata", d_rdata, 128'h0);
        check("reset_i_rdata", i_rdata, 128'h0);

        run(0, mark_a);
        check("dread_rdata", d_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
        run(mark_a, mark_b);
        check("dwrite_keeps_rdata", d_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
        run(mark_b, mark_c);
        check("abort_partial_irdata", i_rdata, 128'h00000050_00000050_00000071_00000070);
        run(mark_c, vecs.size());
        check("ifill_rdata", i_rdata, 128'h00000083_00000082_00000081_00000080);

        // RST asserted mid-beat clears everything without a clock edge
        @(posedge CLK);
        #1;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h500; i_req = 1'b0;
        abort_bus = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h99;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        check("pre_rst_busy", 128'(busy), 128'h1);
        RST = 1'b1;
        #1;
        check("async_rst_outputs", 128'(pack_outputs()), 128'h0);
        check("async_rst_d_rdata", d_rdata, 128'h0);
        check("async_rst_i_rdata", i_rdata, 128'h0);

        // release: a request held in cycle 0 must complete with done in cycle 5
        @(posedge CLK);
        #1;
        RST = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLK);
            #1;
            if (done_cyc != 0) d_req = 1'b0;
            mem_rdata = 32'(32'h90 + k - 1);
            @(negedge CLK);
            if (d_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
            end
        end
        check("post_rst_done_cycle", 128'(done_cyc), 128'd5);
        check("post_rst_done_pulses", 128'(n_done), 128'd1);
        check("post_rst_d_rdata", d_rdata, 128'h00000093_00000092_00000091_00000090);
        check("post_rst_idle", 128'({busy, mem_req, i_done}), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
